// File: rtl/fifo_pkg.sv
// Shared constants for the upstream fifo and its reader: default geometry and output-buffer state encoding.
// No logic and no latency.
// Backpressure: not applicable.
package fifo_pkg;

    localparam int DEFAULT_BUFFER_SIZE = 8;
    localparam int DEFAULT_ITEM_SIZE   = 8;

    // The state encoding doubles as the buffer occupancy.
    localparam logic [1:0] BUF_EMPTY = 2'd0;
    localparam logic [1:0] BUF_ONE   = 2'd1;
    localparam logic [1:0] BUF_TWO   = 2'd2;

endpackage

// File: rtl/fifo.sv
// Upstream item fifo with a registered read port.
// Latency: data_out is valid one cycle after read_en.
// Backpressure: writes are dropped when full, and reads are ignored when empty.
module fifo
    import fifo_pkg::*;
#(
    parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    parameter int ITEM_SIZE   = DEFAULT_ITEM_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic [ITEM_SIZE-1:0] data_in,
    input  logic                 read_en,
    output logic [ITEM_SIZE-1:0] data_out
);

    localparam int PW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic [ITEM_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 wr_ok;
    logic                 rd_ok;

    assign wr_ok = write_en && (cnt != CW'(BUFFER_SIZE));
    assign rd_ok = read_en && (cnt != '0);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) wr_ptr <= (wr_ptr == PW'(BUFFER_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == PW'(BUFFER_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
            else if (!wr_ok && rd_ok) cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry registered output buffer with a valid/ready output.
// Latency: a captured item is visible on out_dat in the cycle after capture.
// Backpressure: the buffer holds up to two items while out_rdy is low; the producer must honour occ.
module skid_buffer
    import fifo_pkg::*;
#(
    parameter int ITEM_SIZE = DEFAULT_ITEM_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [ITEM_SIZE-1:0] in_dat,
    input  logic                 out_rdy,
    output logic                 out_vld,
    output logic [ITEM_SIZE-1:0] out_dat,
    output logic [1:0]           occ
);

    logic [1:0]           state;
    logic [ITEM_SIZE-1:0] head;
    logic [ITEM_SIZE-1:0] tail;
    logic                 hs;

    assign out_vld = (state != BUF_EMPTY);
    assign out_dat = head;
    assign occ     = state;
    assign hs      = out_vld && out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BUF_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (in_vld) begin
                        head  <= in_dat;
                        state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_vld && hs) begin
                        head <= in_dat;
                    end else if (in_vld) begin
                        tail  <= in_dat;
                        state <= BUF_TWO;
                    end else if (hs) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // No capture can arrive here: the reader's credit check blocks the pop that would cause it.
                    if (hs) begin
                        head  <= tail;
                        state <= BUF_ONE;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Drains an upstream fifo into a registered valid/ready stream while tracking the fifo's occupancy.
// Latency: m_valid rises 2 cycles after fifo_read_en; steady-state throughput is one item per cycle.
// Backpressure: pops are credit-limited, so in-flight plus buffered items never exceed two.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    parameter int ITEM_SIZE   = DEFAULT_ITEM_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_seen,
    output logic                                 fifo_read_en,
    input  logic [ITEM_SIZE-1:0]                 fifo_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [ITEM_SIZE-1:0]                 m_data,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]     count,
    output logic                                 empty,
    output logic                                 full
);

    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic       inflight;
    logic       wr_acc;
    logic       hs;
    logic [1:0] occ;
    logic [2:0] credit_used;

    assign empty  = (count == '0);
    assign full   = (count == CW'(BUFFER_SIZE));
    // The full check uses the pre-edge count, so a write is dropped on a full fifo even when a pop occurs in the same cycle.
    assign wr_acc = wr_seen && !full;
    assign hs     = m_valid && m_ready;

    assign credit_used  = {2'b00, inflight} + {1'b0, occ} - {2'b00, hs};
    assign fifo_read_en = !empty && (credit_used < 3'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read_en;
            if (wr_acc && !fifo_read_en)      count <= count + 1'b1;
            else if (!wr_acc && fifo_read_en) count <= count - 1'b1;
        end
    end

    skid_buffer #(
        .ITEM_SIZE (ITEM_SIZE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (inflight),
        .in_dat  (fifo_data),
        .out_rdy (m_ready),
        .out_vld (m_valid),
        .out_dat (m_data),
        .occ     (occ)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for the fifo and fifo_reader pair; a scoreboard queue holds accepted writes and is checked at each handshake.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int BS = 8;
    localparam int IS = 8;
    localparam int CW = $clog2(BS + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic [IS-1:0] data_in;
    logic          fifo_read_en;
    logic [IS-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [IS-1:0] m_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    always #5 clk = ~clk;

    fifo #(.BUFFER_SIZE(BS), .ITEM_SIZE(IS)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .data_in  (data_in),
        .read_en  (fifo_read_en),
        .data_out (fifo_data)
    );

    fifo_reader #(.BUFFER_SIZE(BS), .ITEM_SIZE(IS)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_seen      (write_en),
        .fifo_read_en (fifo_read_en),
        .fifo_data    (fifo_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [IS-1:0] sb [$];
    int            model_cnt;
    int            cyc_n;
    int            first_rd;
    int            first_vld;
    int            last_hs;
    logic          stall_prev;
    logic [IS-1:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle, advance the occupancy model and scoreboard.
    task automatic cyc(input logic wr, input logic [IS-1:0] d, input logic rdy);
        logic acc;
        logic pop;
        write_en = wr;
        data_in  = d;
        m_ready  = rdy;
        @(negedge clk);
        check("count", 32'(count), 32'(model_cnt));
        check("empty", 32'(empty), 32'(model_cnt == 0));
        check("full", 32'(full), 32'(model_cnt == BS));
        check("rd_when_empty", 32'(fifo_read_en & empty), 32'd0);
        if (stall_prev) begin
            check("hold_vld", 32'(m_valid), 32'd1);
            check("hold_dat", 32'(m_data), 32'(held));
        end
        if (fifo_read_en && first_rd < 0) first_rd = cyc_n;
        if (m_valid && first_vld < 0) first_vld = cyc_n;
        if (m_valid && m_ready) begin
            check("sb_has_item", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("m_data", 32'(m_data), 32'(sb.pop_front()));
            last_hs = cyc_n;
        end
        stall_prev = m_valid && !m_ready;
        held       = m_data;
        acc        = wr && (model_cnt < BS);
        pop        = fifo_read_en;
        if (acc) sb.push_back(d);
        model_cnt  = model_cnt + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || m_valid) && n < budget) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
        check("drain_vld", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IS-1:0] v32 [12];
        logic [3:0]    rdy_pat;
        v32 = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63, 8'd127, 8'd255, 8'd17, 8'd21, 8'd99, 8'd77};
        rdy_pat    = 4'b1001;
        rst        = 1'b0;
        write_en   = 1'b0;
        data_in    = '0;
        m_ready    = 1'b0;
        model_cnt  = 0;
        cyc_n      = 0;
        first_rd   = -1;
        first_vld  = -1;
        last_hs    = -1;
        stall_prev = 1'b0;
        held       = '0;

        #12;
        check("rst_vld", 32'(m_valid), 32'd0);
        check("rst_dat", 32'(m_data), 32'd0);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_rd", 32'(fifo_read_en), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Short burst with the consumer always ready.
        cyc(1'b1, 8'd1, 1'b1);
        cyc(1'b1, 8'd3, 1'b1);
        cyc(1'b1, 8'd7, 1'b1);
        cyc(1'b1, 8'd15, 1'b1);
        drain(20);
        check("latency", 32'(first_vld - first_rd), 32'd2);
        check("back_to_back", 32'(last_hs - first_vld), 32'd3);
        check("burst_cnt", 32'(count), 32'd0);

        // Fill while stalled: two items sit in the output buffer, so the fifo fills on the tenth write.
        for (int i = 0; i < 12; i++) cyc(1'b1, v32[i], 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_accepted", 32'(sb.size()), 32'd10);
        drain(40);

        // Stream under a 1,0,0,1 ready pattern.
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h40 + i), rdy_pat[i % 4]);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, rdy_pat[i % 4]);
        drain(40);

        // Simultaneous write and pop at count 4, then at count 8.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        check("cnt_before_4", 32'(count), 32'd4);
        cyc(1'b1, 8'h70, 1'b1);
        check("cnt_wr_pop_4", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h71 + i), 1'b0);
        check("cnt_before_8", 32'(count), 32'd8);
        cyc(1'b1, 8'h7f, 1'b1);
        check("cnt_full_wr_pop", 32'(count), 32'd7);
        drain(40);

        // Reset while a pop is in flight.
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_vld", 32'(m_valid), 32'd0);
        check("mid_rst_cnt", 32'(count), 32'd0);
        check("mid_rst_rd", 32'(fifo_read_en), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        sb.delete();
        model_cnt  = 0;
        stall_prev = 1'b0;
        write_en   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 8'ha5, 1'b1);
        drain(20);

        // Idle fifo with the consumer ready.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, '0, 1'b1);
            check("idle_rd", 32'(fifo_read_en), 32'd0);
            check("idle_vld", 32'(m_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
